pio_debounced_irq: RTL
======================

PIO_DEBOUNCED_IRQ -- requirements
Module: pio_debounced_irq

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: number of input channels, legal range 1..32.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 50000: stable cycles required before a debounced state change, legal range >= 2.
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1: 1 = raw input low means pressed.
REQ-004 SHALL provide parameter EDGE_MODE, default 0: 0 = capture press, 1 = capture release, 2 = capture both.
REQ-005 clk_clk  in  1  single clock; all logic on the rising edge.
REQ-006 reset_reset  in  1  reset, asynchronous and active-high.
REQ-007 keys_export  in  WIDTH  raw asynchronous channel inputs.
REQ-008 avs_address  in  2  word address.
REQ-009 avs_read  in  1  read strobe.
REQ-010 avs_write  in  1  write strobe.
REQ-011 avs_writedata  in  32  write data.
REQ-012 avs_readdata  out  32  registered read data.
REQ-013 keys_debounced  out  WIDTH  debounced state per channel, 1 = pressed.
REQ-014 irq  out  1  interrupt request, active-high, level.

Function
REQ-015 SHALL pass each raw bit through a 2-flop synchroniser, then invert it when ACTIVE_LOW=1, giving synced value s (1 = pressed).
REQ-016 SHALL keep a per-channel counter that clears whenever s equals the debounced bit, and otherwise increments once per cycle.
REQ-017 SHALL toggle a channel's debounced bit, and clear its counter, on the edge where s has differed from the debounced bit for DEBOUNCE_CYCLES consecutive cycles.
REQ-018 Latency from a stable raw change to the keys_debounced change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-019 A raw glitch shorter than DEBOUNCE_CYCLES cycles, measured after synchronisation, SHALL leave keys_debounced unchanged.
REQ-020 SHALL detect a press as a debounced 0->1 transition and a release as a debounced 1->0 transition.
REQ-021 SHALL set the channel's edgecapture bit one cycle after a qualifying transition, qualified per EDGE_MODE.
REQ-022 Register map (read data zero-extended to 32 bits):
- 0 data: read returns keys_debounced; writes ignored.
- 1 irqmask: read/write, bits [WIDTH-1:0].
- 2 edgecapture: read returns captured bits; writing 1 to a bit clears it; writing 0 has no effect.
- 3: reads 0; writes ignored.
REQ-023 Read latency SHALL be fixed at 1 cycle: avs_readdata is valid on the cycle after avs_read and holds until the next read.
REQ-024 There is no waitrequest; writes SHALL take effect on the edge at which avs_write is sampled.
REQ-025 When a capture set and a write-1-clear hit the same bit in the same cycle, the set SHALL win.
REQ-026 When read and write are asserted together, the read SHALL return the pre-write value.
REQ-027 irq SHALL equal the OR of (edgecapture AND irqmask), driven combinationally from registers with no extra delay.
REQ-028 Writes SHALL ignore avs_writedata bits at or above WIDTH; those bits SHALL always read 0.

Reset
REQ-029 reset_reset SHALL act asynchronously and force the following:
- synchroniser flops to the idle level (1 when ACTIVE_LOW=1);
- debounced bits, counters, irqmask, edgecapture, avs_readdata, keys_debounced and irq to 0.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count and SHALL produce no edge capture on release of reset while the input is idle.
REQ-031 After reset deasserts, the first valid clock edge SHALL resume normal operation.

Verification (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, EDGE_MODE=0)
REQ-032 Hold keys_export=4'hF, pulse reset -> all outputs 0; read of addresses 0..3 returns 0.
REQ-033 Drive keys_export[1]=0 and hold it -> keys_debounced=4'h2 exactly 6 cycles later; edgecapture bit1 set 1 cycle after that; irq stays 0 while irqmask=0.
REQ-034 Write irqmask=4'h2 with bit1 captured -> irq=1 on the next cycle; write edgecapture=32'h2 -> irq=0 on the following cycle; read of address 2 returns 0.
REQ-035 Drive keys_export[0] low for 3 synced cycles, then high -> keys_debounced bit0 stays 0 and no capture occurs.
REQ-036 Issue write-1-clear to bit2 in the same cycle bit2 captures a press -> bit2 remains 1.
REQ-037 Assert reset mid-count (2 cycles into debouncing, input held low) -> after reset deasserts, debounce restarts and keys_debounced changes a full 6 cycles after reset release.

Source files
------------

// File: rtl/pio_debounced_irq.sv
// Debounced parallel input port with edge capture and a maskable level interrupt.
// Each channel is synchronised, debounced by a run-length counter, and exposed over a 4-word slave.
module pio_debounced_irq #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] keys_export,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic [WIDTH-1:0] keys_debounced,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] wr_data;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Synchroniser idles at the released level so reset never looks like a press.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_1 <= IDLE_LEVEL;
            sync_2 <= IDLE_LEVEL;
        end else begin
            sync_1 <= keys_export;
            sync_2 <= sync_1;
        end
    end

    assign synced = (ACTIVE_LOW != 0) ? ~sync_2 : sync_2;

    // The counter tracks how long the synced level has disagreed with the debounced bit.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < WIDTH; i++) begin
                if (synced[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cap_set = '0;
        case (EDGE_MODE)
            0:       cap_set = deb & ~deb_prev;
            1:       cap_set = ~deb & deb_prev;
            default: cap_set = deb ^ deb_prev;
        endcase
    end

    assign wr_data      = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    // A capture landing in the same cycle as its write-1-clear must survive.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (avs_write && avs_address == 2'd1) begin
                irq_mask <= wr_data;
            end
            if (avs_write && avs_address == 2'd2) begin
                edge_cap <= (edge_cap & ~wr_data) | cap_set;
            end else begin
                edge_cap <= edge_cap | cap_set;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0:    rd_mux[WIDTH-1:0] = deb;
            2'd1:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd2:    rd_mux[WIDTH-1:0] = edge_cap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    assign keys_debounced = deb;
    assign irq            = |(edge_cap & irq_mask);

endmodule
